// File: rtl/trace_buf_capture_ctrl.sv
// rtl/trace_buf_capture_ctrl.sv - armed trace capture into BRAM with ring, one-shot and triggered modes
module trace_buf_capture_ctrl #(
  parameter int VECTOR_DATA_WIDTH    = 192,
  parameter int TRACE_BUF_DATA_WIDTH = 256,
  parameter int TRACE_BUF_ADDR_WIDTH = 15,
  parameter int TS_WIDTH             = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              arm,
  input  logic                              abort,
  input  logic [1:0]                        mode,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0]   post_trig_len,
  input  logic                              trigger,
  input  logic                              rd_en_100ns,
  input  logic [VECTOR_DATA_WIDTH-1:0]      vctr_fifo_data_out,
  input  logic [31:0]                       trace_buf_bram_addr_slave,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0]   trace_buf_bram_addra,
  output logic [TRACE_BUF_DATA_WIDTH-1:0]   trace_buf_bram_data_in,
  output logic                              trace_buf_we,
  output logic                              trace_buf_en,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0]   trace_buf_bram_addrb,
  output logic                              busy,
  output logic                              done,
  output logic                              wrapped,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0]   trig_addr,
  output logic [TRACE_BUF_ADDR_WIDTH:0]     sample_count
);

  localparam int A = TRACE_BUF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [1:0]     MODE_ONESHOT = 2'd1;
  localparam logic [1:0]     MODE_TRIG    = 2'd2;
  localparam logic [A-1:0]   LAST_ADDR    = '1;
  localparam logic [A-1:0]   PTR_ONE      = {{(A-1){1'b0}}, 1'b1};
  localparam logic [A:0]     CNT_ONE      = {{A{1'b0}}, 1'b1};
  localparam logic [A:0]     FULL_COUNT   = {1'b1, {A{1'b0}}};
  localparam logic [TS_WIDTH-1:0] TS_ONE  = {{(TS_WIDTH-1){1'b0}}, 1'b1};

  state_t                          state_q, state_d;
  logic [A-1:0]                    wr_ptr_q, wr_ptr_d;
  logic                            wrapped_q, wrapped_d;
  logic [A-1:0]                    trig_addr_q, trig_addr_d;
  logic [TS_WIDTH-1:0]             ts_q, ts_d;
  logic [1:0]                      cap_mode_q, cap_mode_d;
  logic [A-1:0]                    post_len_q, post_len_d;
  logic [A-1:0]                    remaining_q, remaining_d;
  logic [A:0]                      count_q, count_d;
  logic                            we_q, we_d;
  logic [A-1:0]                    addra_q, addra_d;
  logic [TRACE_BUF_DATA_WIDTH-1:0] data_q, data_d;
  logic [A-1:0]                    addrb_q, addrb_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            wr_fire;
  logic [A-1:0]                    rd_base;
  logic                            unused_addr_slave_bits;

  assign unused_addr_slave_bits = ^trace_buf_bram_addr_slave[31:A];

  // Next-state, write path and readback address for the capture controller.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wrapped_d   = wrapped_q;
    trig_addr_d = trig_addr_q;
    ts_d        = ts_q;
    cap_mode_d  = cap_mode_q;
    post_len_d  = post_len_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    we_d        = 1'b0;
    addra_d     = addra_q;
    data_d      = data_q;
    wr_fire     = 1'b0;

    // Timestamp free-runs once armed; it is parked at zero only before the first arm.
    if (state_q != ST_IDLE) begin
      ts_d = ts_q + TS_ONE;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm && !abort) begin
          state_d     = ST_CAPTURE;
          wr_ptr_d    = '0;
          wrapped_d   = 1'b0;
          trig_addr_d = '0;
          count_d     = '0;
          // The arm cycle is timestamp 0, so the first capture cycle carries 1.
          ts_d        = TS_ONE;
          cap_mode_d  = (mode == 2'd3) ? MODE_ONESHOT : mode;
          post_len_d  = post_trig_len;
        end
      end
      ST_CAPTURE, ST_POST: begin
        if (abort) begin
          state_d = ST_DONE;
        end else begin
          wr_fire = rd_en_100ns;
          if (state_q == ST_CAPTURE && cap_mode_q == MODE_TRIG && trigger) begin
            // The trigger-cycle sample lands at trig_addr and is not part of the post count.
            trig_addr_d = wr_ptr_q;
            if (post_len_q == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d     = ST_POST;
              remaining_d = post_len_q;
            end
          end else if (state_q == ST_POST && wr_fire) begin
            remaining_d = remaining_q - PTR_ONE;
            if (remaining_q == PTR_ONE) begin
              state_d = ST_DONE;
            end
          end
          if (wr_fire && cap_mode_q == MODE_ONESHOT && wr_ptr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_fire) begin
      we_d    = 1'b1;
      addra_d = wr_ptr_q;
      data_d  = '0;
      data_d[VECTOR_DATA_WIDTH-1:0]              = vctr_fifo_data_out;
      data_d[VECTOR_DATA_WIDTH +: TS_WIDTH]      = ts_q;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      // One-shot stops at the last address, so only ring captures can wrap.
      if (wr_ptr_q == LAST_ADDR && cap_mode_q != MODE_ONESHOT) begin
        wrapped_d = 1'b1;
      end
      count_d = (count_q == FULL_COUNT) ? FULL_COUNT : count_q + CNT_ONE;
    end

    busy_d = (state_d == ST_CAPTURE) || (state_d == ST_POST);
    done_d = (state_d == ST_DONE);

    // Readback offsets are relative to the oldest entry in the buffer.
    rd_base = wrapped_q ? wr_ptr_q : '0;
    addrb_d = rd_base + trace_buf_bram_addr_slave[A-1:0];
  end

  // FSM and all registered outputs; reset returns to an idle, empty buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      trig_addr_q <= '0;
      ts_q        <= '0;
      cap_mode_q  <= '0;
      post_len_q  <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      we_q        <= 1'b0;
      addra_q     <= '0;
      data_q      <= '0;
      addrb_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wrapped_q   <= wrapped_d;
      trig_addr_q <= trig_addr_d;
      ts_q        <= ts_d;
      cap_mode_q  <= cap_mode_d;
      post_len_q  <= post_len_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      we_q        <= we_d;
      addra_q     <= addra_d;
      data_q      <= data_d;
      addrb_q     <= addrb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign trace_buf_bram_addra   = addra_q;
  assign trace_buf_bram_data_in = data_q;
  assign trace_buf_we           = we_q;
  assign trace_buf_en           = 1'b1;
  assign trace_buf_bram_addrb   = addrb_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign wrapped                = wrapped_q;
  assign trig_addr              = trig_addr_q;
  assign sample_count           = count_q;

endmodule

// File: tb/tb_trace_buf_capture_ctrl.sv
// tb/tb_trace_buf_capture_ctrl.sv - scoreboard bench for the trace-buffer capture controller
module tb_trace_buf_capture_ctrl;

  localparam int A    = 4;
  localparam int D    = 16;
  localparam int V    = 24;
  localparam int TW   = 16;
  localparam int DW   = 48;
  localparam int MAXN = 80;

  logic          clk = 1'b0;
  logic          rst, arm, abort, trigger, rd_en;
  logic [1:0]    mode;
  logic [A-1:0]  post_trig_len;
  logic [V-1:0]  vdata;
  logic [31:0]   addr_slave;
  logic [A-1:0]  addra, addrb, trig_addr;
  logic [DW-1:0] din;
  logic          we, en, busy, done, wrapped;
  logic [A:0]    sample_count;

  trace_buf_capture_ctrl #(
    .VECTOR_DATA_WIDTH(V), .TRACE_BUF_DATA_WIDTH(DW),
    .TRACE_BUF_ADDR_WIDTH(A), .TS_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .mode(mode),
    .post_trig_len(post_trig_len), .trigger(trigger), .rd_en_100ns(rd_en),
    .vctr_fifo_data_out(vdata), .trace_buf_bram_addr_slave(addr_slave),
    .trace_buf_bram_addra(addra), .trace_buf_bram_data_in(din),
    .trace_buf_we(we), .trace_buf_en(en), .trace_buf_bram_addrb(addrb),
    .busy(busy), .done(done), .wrapped(wrapped), .trig_addr(trig_addr),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [A-1:0]  addr;
    logic [DW-1:0] data;
    int            at;
  } wr_t;

  wr_t exp_q[$];

  logic          s_valid [MAXN];
  logic [V-1:0]  s_data  [MAXN];
  logic          s_trig  [MAXN];
  logic          s_arm   [MAXN];
  logic          exp_v   [MAXN];
  logic [A-1:0]  exp_a   [MAXN];
  logic [DW-1:0] exp_d   [MAXN];

  int m_ptr, m_cnt, m_taddr;
  bit m_wrapped;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pack(input int t, input logic [V-1:0] d);
    logic [DW-1:0] w;
    w = '0;
    w[V-1:0]     = d;
    w[V +: TW]   = TW'(t);
    return w;
  endfunction

  // Scoreboard monitor: every write the DUT presents must match the oldest expectation.
  wr_t got;
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: addr=%0h data=%0h with nothing expected", addra, din);
      end else begin
        got = exp_q.pop_front();
        check("wr_addr", 64'(addra), 64'(got.addr));
        check("wr_data", 64'(din), 64'(got.data));
        check("wr_cycle", 64'(cyc), 64'(got.at));
      end
    end
  end

  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = V'($urandom);
      s_trig[i]  = 1'b0;
      s_arm[i]   = 1'b0;
    end
  endtask

  // Reference model: walks the cycle list applying the capture rules with plain integers.
  task automatic run_model(input int n, input int m_in, input int len);
    int  m, ptr, cnt, rem, old;
    bit  active, post, wrote;
    m = (m_in == 3) ? 1 : m_in;
    active = 1; post = 0; ptr = 0; cnt = 0; rem = 0;
    m_wrapped = 0; m_taddr = 0;
    for (int i = 0; i < MAXN; i++) exp_v[i] = 1'b0;
    for (int i = 1; i < n - 1; i++) begin
      if (active) begin
        wrote = s_valid[i];
        old   = ptr;
        if (wrote) begin
          exp_v[i] = 1'b1;
          exp_a[i] = A'(ptr);
          exp_d[i] = pack(i, s_data[i]);
          ptr = (ptr + 1) % D;
          if (cnt < D) cnt++;
          if (old == D - 1 && m != 1) m_wrapped = 1;
        end
        if (m == 1 && wrote && old == D - 1) begin
          active = 0;
        end else if (m == 2 && !post && s_trig[i]) begin
          m_taddr = old;
          if (len == 0) active = 0;
          else begin
            post = 1;
            rem  = len;
          end
        end else if (post && wrote) begin
          rem--;
          if (rem == 0) active = 0;
        end
      end
    end
    m_ptr = ptr;
    m_cnt = cnt;
  endtask

  task automatic idle_inputs();
    arm = 0; abort = 0; trigger = 0; rd_en = 0; rst = 0;
  endtask

  // Drives one armed run; the last cycle carries abort, or rst when use_rst is set.
  task automatic run_scn(input int n, input int m, input int len, input bit use_rst);
    wr_t e;
    run_model(n, m, len);
    for (int i = 0; i < n; i++) begin
      arm           = (i == 0) || s_arm[i];
      mode          = (i == 0) ? 2'(m) : 2'($urandom);
      post_trig_len = (i == 0) ? A'(len) : A'($urandom);
      trigger       = s_trig[i];
      rd_en         = s_valid[i];
      vdata         = s_data[i];
      abort         = !use_rst && (i == n - 1);
      rst           = use_rst && (i == n - 1);
      if (exp_v[i]) begin
        e.addr = exp_a[i];
        e.data = exp_d[i];
        e.at   = cyc + 1;
        exp_q.push_back(e);
      end
      if (use_rst && i == n - 1) check("busy_before_rst", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    idle_inputs();
    if (use_rst) begin
      check("rst_we", 64'(we), 64'd0);
      check("rst_addra", 64'(addra), 64'd0);
      check("rst_data", 64'(din), 64'd0);
      check("rst_addrb", 64'(addrb), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_wrapped", 64'(wrapped), 64'd0);
      check("rst_trig_addr", 64'(trig_addr), 64'd0);
      check("rst_count", 64'(sample_count), 64'd0);
      check("rst_en", 64'(en), 64'd1);
      rd_en = 1;
      repeat (4) begin
        vdata = V'($urandom);
        @(posedge clk); #1;
      end
      rd_en = 0;
      @(posedge clk); #1;
      check("rst_pending", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic post_checks(input logic [31:0] o1, input logic [31:0] o2);
    int base;
    repeat (2) @(posedge clk);
    #1;
    check("done", 64'(done), 64'd1);
    check("busy", 64'(busy), 64'd0);
    check("wrapped", 64'(wrapped), 64'(m_wrapped));
    check("sample_count", 64'(sample_count), 64'(m_cnt));
    check("trig_addr", 64'(trig_addr), 64'(m_taddr));
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    base = m_wrapped ? m_ptr : 0;
    addr_slave = o1;
    @(posedge clk); #1;
    check("addrb_a", 64'(addrb), 64'((base + int'(o1 % 32'd16)) % D));
    addr_slave = o2;
    @(posedge clk); #1;
    check("addrb_b", 64'(addrb), 64'((base + int'(o2 % 32'd16)) % D));
    addr_slave = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1; mode = 0; post_trig_len = 0; vdata = 0; addr_slave = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_we", 64'(we), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_count", 64'(sample_count), 64'd0);
    check("reset_addra", 64'(addra), 64'd0);
    check("reset_en", 64'(en), 64'd1);
    rst = 0;

    // arm together with abort from IDLE must not start a capture
    arm = 1; abort = 1; rd_en = 1; vdata = V'($urandom);
    @(posedge clk); #1;
    arm = 0; abort = 0;
    check("armabort_busy", 64'(busy), 64'd0);
    check("armabort_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rd_en = 0;
    check("armabort_busy2", 64'(busy), 64'd0);

    // one-shot: 20 samples, 16 written
    clear_stim();
    for (int i = 1; i <= 20; i++) s_valid[i] = 1'b1;
    run_scn(23, 1, 0, 0);
    post_checks(32'd0, 32'd5);

    // continuous ring, extra arm mid-run ignored, abort after 20 samples
    clear_stim();
    for (int i = 1; i <= 20; i++) s_valid[i] = 1'b1;
    s_valid[21] = 1'b1;
    s_arm[10]   = 1'b1;
    run_scn(22, 0, 0, 0);
    post_checks(32'd0, 32'd13);

    // triggered, post length 5, trigger with 7th sample
    clear_stim();
    for (int i = 1; i <= 14; i++) s_valid[i] = 1'b1;
    s_trig[7] = 1'b1;
    s_trig[9] = 1'b1;
    run_scn(16, 2, 5, 0);
    post_checks(32'd2, 32'd9);

    // triggered, post length 0, trigger at wr_ptr 3
    clear_stim();
    for (int i = 1; i <= 8; i++) s_valid[i] = 1'b1;
    s_trig[4] = 1'b1;
    run_scn(10, 2, 0, 0);
    post_checks(32'd1, 32'd3);

    // timestamp: single sample 0xABC at cycle 5 after arm
    clear_stim();
    s_valid[5] = 1'b1;
    s_data[5]  = 24'hABC;
    run_scn(10, 0, 0, 0);
    post_checks(32'd0, 32'd1);

    // reset while in POST
    clear_stim();
    for (int i = 1; i < 8; i++) s_valid[i] = 1'b1;
    s_trig[3] = 1'b1;
    run_scn(8, 2, 10, 1);

    // randomized runs, including reserved mode 3
    for (int r = 0; r < 10; r++) begin
      int n, m, len;
      clear_stim();
      n   = $urandom_range(12, 60);
      m   = $urandom_range(0, 3);
      len = $urandom_range(0, D - 1);
      for (int i = 0; i < n; i++) begin
        s_valid[i] = ($urandom_range(0, 9) < 7);
        s_trig[i]  = ($urandom_range(0, 9) == 0);
      end
      run_scn(n, m, len, 0);
      post_checks($urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
